// File: rtl/tms_uart_tx_if.sv
// Host-side bus of the UART transmitter: byte push, divisor and FIFO/overflow status.
// Latency: pure wiring. No registers live in the interface.
// Backpressure: the host watches full. Writes made while full is high are dropped and reported on overflow.
//
// master : host side. It drives divisor, wdata, wr_en and ovf_clr, and reads full, empty and overflow.
// slave  : transmitter side. It has the opposite directions.
interface tms_uart_tx_if #(
    parameter int DIV_W = 16
);
    logic [DIV_W-1:0] divisor;   // bit period minus one, in clock cycles
    logic [7:0]       wdata;     // byte to enqueue
    logic             wr_en;     // enqueue strobe, one byte per cycle
    logic             ovf_clr;   // clear the sticky overflow flag
    logic             full;      // FIFO holds FIFO_DEPTH bytes
    logic             empty;     // FIFO holds no bytes
    logic             overflow;  // sticky: a write was dropped

    modport master (
        output divisor, wdata, wr_en, ovf_clr,
        input  full, empty, overflow
    );

    modport slave (
        input  divisor, wdata, wr_en, ovf_clr,
        output full, empty, overflow
    );
endinterface

// File: rtl/tms_uart_tx.sv
// 8N1 UART transmitter with a small byte FIFO and a per-frame programmable baud divisor.
// Latency: a byte written into an empty FIFO while idle pulls tx low one clock later.
// Backpressure: full is registered. A write while full is dropped and sets the sticky overflow flag.
//
// Ports: wb_clk_i (only clock), rst_n (async active-low), bus (tms_uart_tx_if.slave:
//        divisor/wdata/wr_en/ovf_clr in, full/empty/overflow out), tx (serial out, idle high),
//        busy (a frame is in progress on tx).
// Optional: define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module tms_uart_tx #(
    parameter int FIFO_DEPTH = 4,   // power of two, minimum 2
    parameter int DIV_W      = 16
) (
    input  logic          wb_clk_i,
    input  logic          rst_n,
    tms_uart_tx_if.slave  bus,
    output logic          tx,
    output logic          busy
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_TX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } state_t;

    // FIFO storage and bookkeeping
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count, count_nxt;
    logic             full_q, empty_q, ovf_q;

    // Serialiser state
    state_t           state;
    logic [7:0]       shift;
    logic [DIV_W-1:0] period;
    logic [DIV_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
`ifdef UART_TX_PARITY_EN
    logic             par_q;
`endif

    logic       push, drop, pop, bit_end;
    logic [7:0] head;

    assign push    = bus.wr_en & ~full_q;
    assign drop    = bus.wr_en & full_q;
    assign bit_end = (baud_cnt == period);
    assign head    = mem[rd_ptr];
    // A new frame is taken either from idle or on the last cycle of a stop bit.
    // The second case is what makes back-to-back frames gapless.
    assign pop     = ~empty_q & ((state == ST_IDLE) | ((state == ST_STOP) & bit_end));

    assign bus.full     = full_q;
    assign bus.empty    = empty_q;
    assign bus.overflow = ovf_q;

    always_comb begin
        count_nxt = count;
        if (push & ~pop)
            count_nxt = count + CNT_W'(1);
        else if (pop & ~push)
            count_nxt = count - CNT_W'(1);
    end

    always_ff @(posedge wb_clk_i) begin
        if (push)
            mem[wr_ptr] <= bus.wdata;
    end

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            count   <= count_nxt;
            full_q  <= (count_nxt == CNT_W'(FIFO_DEPTH));
            empty_q <= (count_nxt == '0);
            // A dropped write takes priority over a same-cycle clear, so the event is never lost.
            if (drop)
                ovf_q <= 1'b1;
            else if (bus.ovf_clr)
                ovf_q <= 1'b0;
        end
    end

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            shift    <= '0;
            period   <= '0;
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx       <= 1'b1;
            busy     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    tx   <= 1'b1;
                    busy <= 1'b0;
                end
                ST_START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        tx       <= shift[0];
                        bit_idx  <= '0;
                        state    <= ST_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + DIV_W'(1);
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        shift    <= shift >> 1;
                        bit_idx  <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            tx    <= par_q;
                            state <= ST_PARITY;
`else
                            tx    <= 1'b1;
                            state <= ST_STOP;
`endif
                        end else begin
                            // shift[1] is the bit that becomes shift[0] after this edge.
                            tx <= shift[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + DIV_W'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        tx       <= 1'b1;
                        state    <= ST_STOP;
                    end else begin
                        baud_cnt <= baud_cnt + DIV_W'(1);
                    end
                end
`endif
                ST_STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        tx       <= 1'b1;
                        busy     <= 1'b0;
                        state    <= ST_IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + DIV_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // Frame load overrides whatever the case above chose. The divisor is sampled only
            // here, so a mid-frame change first takes effect on the next frame.
            if (pop) begin
                shift    <= head;
                period   <= bus.divisor;
                baud_cnt <= '0;
                tx       <= 1'b0;
                busy     <= 1'b1;
                state    <= ST_START;
`ifdef UART_TX_PARITY_EN
                par_q    <= ^head;
`endif
            end
        end
    end
endmodule

// File: tb/tb_tms_uart_tx.sv
module tb_tms_uart_tx;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    logic wb_clk_i = 1'b0;
    logic rst_n    = 1'b0;
    logic tx, busy;

    tms_uart_tx_if #(.DIV_W(16)) bus ();

    tms_uart_tx #(.FIFO_DEPTH(4), .DIV_W(16)) dut (
        .wb_clk_i (wb_clk_i),
        .rst_n    (rst_n),
        .bus      (bus),
        .tx       (tx),
        .busy     (busy)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int cyc = 0;
    always @(posedge wb_clk_i) cyc <= cyc + 1;

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp)
            pass_cnt++;
        else
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
    endtask

    // Expected tx level for frame bit k of byte d: start, LSB-first data, [parity], stop.
    function automatic logic frame_bit(input logic [7:0] d, input int k);
        if (k == 0)
            return 1'b0;
        if (k <= 8)
            return d[k-1];
        if (k == 9 && FRAME_BITS == 11)
            return ^d;
        return 1'b1;
    endfunction

    // Scoreboard: bytes expected on the line, in order.
    logic [7:0] exp_q[$];
    int         start_q[$];
    logic       par_q[$];
    int         rx_count = 0;
    int         rx_div   = 3;

    // Receiver model: sample each bit in its middle, check stop, pop scoreboard.
    initial begin
        bit         act;
        int         t, p, k;
        logic [7:0] b;
        act = 0;
        t   = 0;
        b   = '0;
        forever begin
            @(negedge wb_clk_i);
            if (!rst_n) begin
                act = 0;
            end else begin
                p = rx_div + 1;
                if (!act) begin
                    if (tx === 1'b0) begin
                        act = 1;
                        t   = 0;
                        start_q.push_back(cyc);
                    end
                end else begin
                    t++;
                end
                if (act && (t % p) == p / 2) begin
                    k = t / p;
                    if (k >= 1 && k <= 8)
                        b[k-1] = tx;
                    else if (k == 9 && FRAME_BITS == 11)
                        par_q.push_back(tx);
                    if (k == FRAME_BITS - 1) begin
                        check("rx_stop_bit", int'(tx), 1);
                        if (exp_q.size() == 0) begin
                            total_cnt++;
                            $display("FAIL rx_unexpected_frame: got byte 0x%0h expected no frame", b);
                        end else begin
                            check("rx_byte", int'(b), int'(exp_q.pop_front()));
                        end
                        rx_count++;
                        act = 0;
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [15:0] div;
        logic [7:0]  dat;
        int          busy_len;   // cycles busy stays high, starting at E+1
    } vec_t;

    task automatic wait_frames(input int target, input int limit, input string name);
        int n;
        n = 0;
        while (rx_count < target && n < limit) begin
            @(negedge wb_clk_i);
            n++;
        end
        check(name, rx_count, target);
    endtask

    initial begin
        vec_t       vecs[5];
        logic [7:0] ovf_bytes[6];
        int         bad, p, target, s0, gap;

        bus.divisor = 16'd3;
        bus.wdata   = 8'h00;
        bus.wr_en   = 1'b0;
        bus.ovf_clr = 1'b0;

        vecs[0] = '{16'd3, 8'hA5, FRAME_BITS * 4};
        vecs[1] = '{16'd0, 8'h5A, FRAME_BITS * 1};
        vecs[2] = '{16'd1, 8'h00, FRAME_BITS * 2};
        vecs[3] = '{16'd2, 8'hFF, FRAME_BITS * 3};
        vecs[4] = '{16'd5, 8'h81, FRAME_BITS * 6};

        // Reset state
        repeat (3) @(negedge wb_clk_i);
        rst_n = 1'b1;
        @(negedge wb_clk_i);
        check("reset_tx",       int'(tx),           1);
        check("reset_full",     int'(bus.full),     0);
        check("reset_empty",    int'(bus.empty),    1);
        check("reset_busy",     int'(busy),         0);
        check("reset_overflow", int'(bus.overflow), 0);

        // Idle hold
        bad = 0;
        repeat (200) begin
            @(negedge wb_clk_i);
            if (tx !== 1'b1 || bus.empty !== 1'b1 || busy !== 1'b0 || bus.overflow !== 1'b0)
                bad++;
        end
        check("idle_hold_bad_cycles", bad, 0);

        // Single frames at several divisors, with a mid-frame divisor change that must not matter
        for (int i = 0; i < 5; i++) begin
            p           = int'(vecs[i].div) + 1;
            rx_div      = int'(vecs[i].div);
            bus.divisor = vecs[i].div;
            exp_q.push_back(vecs[i].dat);
            bus.wdata   = vecs[i].dat;
            bus.wr_en   = 1'b1;
            @(negedge wb_clk_i);           // edge E has just occurred
            bus.wr_en   = 1'b0;
            check("pre_start_tx", int'(tx), 1);
            bad = 0;
            for (int c = 1; c <= vecs[i].busy_len; c++) begin
                @(negedge wb_clk_i);
                if (c == 2)
                    bus.divisor = vecs[i].div ^ 16'h0005;
                if (tx !== frame_bit(vecs[i].dat, (c - 1) / p) || busy !== 1'b1)
                    bad++;
            end
            check("frame_wave_bad_cycles", bad, 0);
            @(negedge wb_clk_i);
            check("busy_fall", int'(busy), 0);
            check("tx_back_idle", int'(tx), 1);
            bus.divisor = vecs[i].div;
            repeat (3) @(negedge wb_clk_i);
        end

        // Back-to-back frames, divisor=1
        bus.divisor = 16'd1;
        rx_div      = 1;
        s0          = start_q.size();
        target      = rx_count + 2;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        bus.wr_en = 1'b1;
        bus.wdata = 8'h00;
        @(negedge wb_clk_i);
        bus.wdata = 8'hFF;
        @(negedge wb_clk_i);
        bus.wr_en = 1'b0;
        wait_frames(target, 200, "b2b_frames");
        gap = (start_q.size() >= s0 + 2) ? start_q[s0+1] - start_q[s0] : -1;
        check("b2b_start_gap", gap, FRAME_BITS * 2);

        // Full / overflow, divisor=100; sixth write collides with ovf_clr and must win
        repeat (5) @(negedge wb_clk_i);
        bus.divisor = 16'd100;
        rx_div      = 100;
        ovf_bytes   = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        target      = rx_count + 5;
        for (int i = 0; i < 5; i++)
            exp_q.push_back(ovf_bytes[i]);
        for (int i = 0; i < 6; i++) begin
            bus.wdata   = ovf_bytes[i];
            bus.wr_en   = 1'b1;
            bus.ovf_clr = (i == 5);
            @(negedge wb_clk_i);
            if (i == 4) begin
                check("full_after_5", int'(bus.full), 1);
                check("no_ovf_yet", int'(bus.overflow), 0);
            end
        end
        bus.wr_en   = 1'b0;
        bus.ovf_clr = 1'b0;
        check("ovf_set_wins", int'(bus.overflow), 1);
        @(negedge wb_clk_i);
        check("ovf_sticky", int'(bus.overflow), 1);
        bus.ovf_clr = 1'b1;
        @(negedge wb_clk_i);
        bus.ovf_clr = 1'b0;
        check("ovf_cleared", int'(bus.overflow), 0);
        wait_frames(target, 7000, "ovf_frames");
        repeat (1200) @(negedge wb_clk_i);
        check("ovf_exactly_5_frames", rx_count, target);
        check("ovf_end_empty", int'(bus.empty), 1);
        check("ovf_end_busy",  int'(busy), 0);

        // Reset during data bit 3 of 0x3C, divisor=7
        bus.divisor = 16'd7;
        rx_div      = 7;
        bus.wdata   = 8'h3C;
        bus.wr_en   = 1'b1;
        @(negedge wb_clk_i);
        bus.wr_en   = 1'b0;
        repeat (34) @(negedge wb_clk_i);   // inside bit 3, which runs from E+33 to E+40
        check("pre_reset_busy", int'(busy), 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset_tx",    int'(tx),        1);
        check("async_reset_busy",  int'(busy),      0);
        check("async_reset_empty", int'(bus.empty), 1);
        repeat (3) @(negedge wb_clk_i);
        rst_n = 1'b1;
        s0  = start_q.size();
        bad = 0;
        repeat (300) begin
            @(negedge wb_clk_i);
            if (tx !== 1'b1 || busy !== 1'b0)
                bad++;
        end
        check("no_residual_frame", bad, 0);
        check("no_residual_start", start_q.size(), s0);

`ifdef UART_TX_PARITY_EN
        // Parity frames, divisor=0
        bus.divisor = 16'd0;
        rx_div      = 0;
        s0          = start_q.size();
        target      = rx_count + 2;
        par_q.delete();
        exp_q.push_back(8'h07);
        exp_q.push_back(8'h03);
        bus.wr_en = 1'b1;
        bus.wdata = 8'h07;
        @(negedge wb_clk_i);
        bus.wdata = 8'h03;
        @(negedge wb_clk_i);
        bus.wr_en = 1'b0;
        wait_frames(target, 100, "par_frames");
        check("par_bit_07", (par_q.size() > 0) ? int'(par_q[0]) : -1, 1);
        check("par_bit_03", (par_q.size() > 1) ? int'(par_q[1]) : -1, 0);
        gap = (start_q.size() >= s0 + 2) ? start_q[s0+1] - start_q[s0] : -1;
        check("par_frame_len", gap, 11);
`endif

        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/tms_uart_tx.md
Name: tms_uart_tx

Overview:
- Byte-wide UART transmitter, 8N1, for the TMS1x00 user-project wrapper.
- Drives the serial line routed to mprj_io[6], which the bench's UART receiver model samples.
- The core or management side pushes bytes into a 4-entry FIFO.
- The block serialises each byte LSB-first at a programmable baud rate, using a clock-cycle divisor.

Parameters:
- FIFO_DEPTH, 4: number of queued bytes; must be a power of two, minimum 2.
- DIV_W, 16: width of the baud divisor input.

Ports:
- wb_clk_i  input  1  system clock; the only clock.
- rst_n  input  1  asynchronous, active-low reset.
- divisor  input  DIV_W  bit period minus one, in wb_clk_i cycles.
- wdata  input  8  byte to enqueue.
- wr_en  input  1  enqueue strobe; one byte per cycle while high.
- ovf_clr  input  1  clears the overflow flag.
- tx  output  1  serial output; idle high.
- full  output  1  FIFO holds FIFO_DEPTH bytes.
- empty  output  1  FIFO holds 0 bytes.
- busy  output  1  a frame is in progress on tx.
- overflow  output  1  sticky: a write was dropped.

Behaviour:
- Reset values: tx=1, full=0, empty=1, busy=0, overflow=0. FIFO pointers, count, FSM, bit counter and baud counter all clear.
- Reset is asserted and deasserted asynchronously. A frame cut short by reset is abandoned, and tx returns high immediately.
- FIFO:
  - full and empty are registered from the count.
  - A write with wr_en=1 and full=0 is accepted at rising edge E.
  - A write while full=1 is dropped and sets overflow at the next edge. This holds even if a pop occurs in the same cycle.
  - Simultaneous accepted write and pop leave the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Overflow flag: ovf_clr clears it. If ovf_clr and a dropped write occur in the same cycle, the set wins.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - tx=1, busy=0.
  - On an edge where the FIFO is non-empty: pop the head into the shift register, latch divisor into an internal period register, set tx=0, set busy=1, go to START.
  - A byte written at edge E into an empty FIFO while IDLE therefore produces a falling tx at edge E+1.
- Baud counter:
  - Reloads to 0 at each bit start and counts up to the latched period.
  - Each bit lasts exactly (period+1) cycles. divisor=0 gives 1 cycle per bit.
  - Changing divisor mid-frame has no effect until the next frame.
- START: after one bit period, drive tx=shift[0] and go to DATA with bit index 0.
- DATA:
  - Each bit period ends with a shift right and the index incrementing.
  - After bit 7's period, set tx=1 and go to STOP.
- STOP:
  - After one bit period, if the FIFO is non-empty: pop, set tx=0 and re-enter START in the same edge. There is no idle gap between frames.
  - Otherwise, go to IDLE with busy=0.
- busy is high from the start-bit edge through the final edge of the stop bit.
- Frame length without parity is 10 bit periods.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP.
  - tx carries the even-parity bit (XOR of the 8 data bits) for one bit period.
  - Frame length becomes 11 bit periods.
- Undefined: no PARITY state and no parity logic. Frame is 10 bit periods, as described in Behaviour.

Test Plan:
- Reset and idle: with no writes, tx, empty, busy and overflow hold at 1, 1, 0 and 0 for 200 cycles.
- Single byte, divisor=3:
  - Stimulus: write 0xA5 at edge E.
  - tx goes low at E+1 and holds for 4 cycles.
  - Data bits follow in the order 1,0,1,0,0,1,0,1 at 4 cycles each, then the stop bit is high for 4 cycles.
  - busy falls at E+41.
- Back-to-back, divisor=1:
  - Stimulus: write 0x00 and 0xFF on consecutive cycles.
  - Second start bit begins exactly 20 cycles after the first, with no idle high between the frames beyond the stop bit.
- Full and overflow, divisor=100:
  - Stimulus: write 6 bytes on consecutive cycles.
  - Bytes 1-5 are accepted (1 popped immediately, 4 queued).
  - Byte 6 is dropped: full=1, then overflow=1.
  - After ovf_clr, overflow=0. Exactly 5 frames are transmitted.
- Reset mid-frame, divisor=7:
  - Stimulus: assert rst_n low during data bit 3 of 0x3C.
  - tx goes to 1 asynchronously, and empty=1, busy=0.
  - After release, no residual frame is sent.
- Parity (UART_TX_PARITY_EN), divisor=0:
  - 0x07 gives parity bit 1; 0x03 gives parity bit 0.
  - Each frame is 11 cycles long.
